// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types for the handshake multiply/accumulate unit:
//                FSM state encoding, latched operation descriptor and an
//                elaboration-time width check helper.
//  Revision    : 1.0  initial release
// ============================================================================
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mac_state_e;

  // Operation attributes captured at accept and held for the whole operation.
  typedef struct packed {
    logic signed_mode;
    logic acc_en;
    logic acc_clr;
    logic sign;          // result must be negated after the unsigned core
  } mac_op_t;

  // True when the result width can hold a full-precision product.
  function automatic bit sat_width(input int data_w, input int result_w);
    return (data_w >= 2) && (result_w >= 2 * data_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_core
//  Description : Unsigned iterative shift-add multiplier, one multiplier bit
//                per cycle, LSB first. start_i loads the operands; busy_o is
//                high for DATA_WIDTH cycles, after which product_o is final
//                and held until the next start_i.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                start_i        load operands and begin
//                mcand_i        multiplicand (unsigned)
//                mplier_i       multiplier (unsigned)
//                busy_o         iteration in progress
//                product_o      2*DATA_WIDTH-bit product
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [DATA_WIDTH-1:0]     mcand_i,
  input  logic [DATA_WIDTH-1:0]     mplier_i,
  output logic                      busy_o,
  output logic [2*DATA_WIDTH-1:0]   product_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);

  logic [2*DATA_WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
  logic [DATA_WIDTH-1:0]   mplier_q;  // multiplier, shifted right each step
  logic [2*DATA_WIDTH-1:0] prod_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, mcand_i};
      mplier_q <= mplier_i;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (cnt_q == C_LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o    = busy_q;
  assign product_o = prod_q;

endmodule
`default_nettype wire

// File: rtl/seq_mac_hs.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mac_hs
//  Description : Sequential multiply / multiply-accumulate with valid/ready
//                operand handshake and done/done_ready result handshake.
//                Signed operands are converted to magnitudes for the unsigned
//                core and the sign is re-applied on completion.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                a, b              operands (sampled at accept)
//                valid / ready     operand handshake (ready only in IDLE)
//                mode_signed       two's complement operands
//                acc_en, acc_clr   accumulate / clear accumulator first
//                out, done         result and its valid flag
//                done_ready        result consumer ready
//                overflow          sticky accumulate overflow
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mac_hs
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic                    valid,
  input  logic                    mode_signed,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic                    ready,
  output logic [RESULT_WIDTH-1:0] out,
  output logic                    done,
  input  logic                    done_ready,
  output logic                    overflow
);

  localparam int PW = 2 * DATA_WIDTH;

  if (!sat_width(DATA_WIDTH, RESULT_WIDTH)) begin : g_bad_width
    $error("seq_mac_hs: RESULT_WIDTH must be >= 2*DATA_WIDTH and DATA_WIDTH >= 2");
  end

  mac_state_e              state_q, state_d;
  mac_op_t                 op_q, op_d;
  logic [RESULT_WIDTH-1:0] out_q, out_d;
  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;

  logic                    start;
  logic                    a_neg, b_neg;
  logic [DATA_WIDTH-1:0]   a_mag, b_mag;
  logic                    core_busy;
  logic [PW-1:0]           core_prod;
  logic [PW-1:0]           prod_signed;
  logic [RESULT_WIDTH-1:0] prod_ext;
  logic [RESULT_WIDTH-1:0] acc_base;
  logic [RESULT_WIDTH:0]   sum;
  logic                    add_ovf;

  assign start = valid && (state_q == IDLE);

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  assign a_neg = mode_signed && a[DATA_WIDTH-1];
  assign b_neg = mode_signed && b[DATA_WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  seq_mult_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .mcand_i   (a_mag),
    .mplier_i  (b_mag),
    .busy_o    (core_busy),
    .product_o (core_prod)
  );

  // Result path, valid in the cycle BUSY sees the core go idle.
  assign prod_signed = op_q.sign ? -core_prod : core_prod;
  assign prod_ext    = op_q.signed_mode ? RESULT_WIDTH'($signed(prod_signed))
                                        : RESULT_WIDTH'(prod_signed);
  assign acc_base    = op_q.acc_clr ? '0 : acc_q;
  assign sum         = {1'b0, acc_base} + {1'b0, prod_ext};
  assign add_ovf     = op_q.signed_mode
                     ? ((acc_base[RESULT_WIDTH-1] == prod_ext[RESULT_WIDTH-1]) &&
                        (sum[RESULT_WIDTH-1] != acc_base[RESULT_WIDTH-1]))
                     : sum[RESULT_WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    out_d   = out_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d.signed_mode = mode_signed;
          op_d.acc_en      = acc_en;
          op_d.acc_clr     = acc_en && acc_clr;
          op_d.sign        = a_neg ^ b_neg;
          state_d          = BUSY;
        end
      end
      BUSY: begin
        if (!core_busy) begin
          if (op_q.acc_en) begin
            acc_d = sum[RESULT_WIDTH-1:0];
            out_d = sum[RESULT_WIDTH-1:0];
            ovf_d = (op_q.acc_clr ? 1'b0 : ovf_q) | add_ovf;
          end else begin
            out_d = prod_ext;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      out_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire
